// File: rtl/div_result_fifo.sv
// rtl/div_result_fifo.sv - circular result FIFO behind the 8b/5b divider (option: DIV_RESULT_FIFO_BYPASS_EN)
module div_result_fifo #(
  parameter int DEPTH = 4,
  parameter int Q_BW  = 8,
  parameter int R_BW  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_in_valid,
  input  logic [Q_BW-1:0]              i_q,
  input  logic [R_BW-1:0]              i_r,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [Q_BW-1:0]              o_q,
  output logic [R_BW-1:0]              o_r,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_overflow,
  output logic [50:0]                  number
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W  = Q_BW + R_BW;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Library cell transistor counts
  localparam int T_DFF  = 24;
  localparam int T_MUX2 = 12;
  localparam int T_AND2 = 6;
  localparam int T_CTRL = 96;   // pointer incrementers, count up/down, full/empty compare
  localparam int N_FLOPS   = DEPTH * W + 2 * AW + CW + 1;
  localparam int N_HEADMUX = (DEPTH - 1) * W;
  localparam int N_GATES   = W;  // zero the head when empty
`ifdef DIV_RESULT_FIFO_BYPASS_EN
  localparam int N_BYPMUX  = W + 1;
`else
  localparam int N_BYPMUX  = 0;
`endif
  localparam int N_TOTAL = N_FLOPS * T_DFF + (N_HEADMUX + N_BYPMUX) * T_MUX2
                         + N_GATES * T_AND2 + T_CTRL;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [W-1:0]  mem [DEPTH];

  logic          head_valid;
  logic          out_valid;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic [W-1:0]  head;

  // Head selection, handshake decode and push acceptance
  always_comb begin
    head       = '0;
    head_valid = (count != '0);
    out_valid  = head_valid;
    if (head_valid) head = mem[rd_ptr];
    pop   = head_valid && i_out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    wr_en = i_in_valid && ((count != FULL_CNT) || pop);
    drop  = i_in_valid && (count == FULL_CNT) && !pop;
`ifdef DIV_RESULT_FIFO_BYPASS_EN
    // Empty FIFO: present the divider result directly; store it only if not consumed now
    if (!head_valid && i_in_valid) begin
      out_valid = 1'b1;
      head      = {i_q, i_r};
      if (i_out_ready) wr_en = 1'b0;
    end
`endif
  end

  // Pointer, occupancy, storage and sticky overflow update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {i_q, i_r};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (drop) overflow <= 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_out_valid = out_valid;
  assign {o_q, o_r}  = head;
  assign o_count     = count;
  assign o_full      = (count == FULL_CNT);
  assign o_overflow  = overflow;
  assign number      = 51'(N_TOTAL);

endmodule
